// File: rtl/bcd_count3_timer_pkg.sv
// Shared definitions for the three-digit BCD timer and any display logic
// that needs to agree with it on digit range, run/stop encoding and the
// default tick divider.
package bcd_count3_timer_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
   localparam int DEFAULT_DIV = 50000000;

   typedef enum logic {
      STOP = 1'b0,
      RUN  = 1'b1
   } timerState_t;

   // True when a digit sits at its top value and will roll over on the next enable
   function automatic logic isDigitMax(input logic [DIGIT_W-1:0] value);
      return value == DIGIT_MAX;
   endfunction

endpackage

// File: rtl/bcd_count3_timer_if.sv
// Control and display bundle of the BCD timer: the pushbutton level and
// clear go toward the timer, the digits and status flags come back.
interface bcd_count3_timer_if;
   import bcd_count3_timer_pkg::*;

   logic               startStop;
   logic               clear;
   logic [DIGIT_W-1:0] bcd0;
   logic [DIGIT_W-1:0] bcd1;
   logic [DIGIT_W-1:0] bcd2;
   logic               running;
   logic               wrap;

   modport master (
      output startStop, clear,
      input  bcd0, bcd1, bcd2, running, wrap
   );

   modport slave (
      input  startStop, clear,
      output bcd0, bcd1, bcd2, running, wrap
   );

endinterface

// File: rtl/bcd_count3_timer_digit.sv
// One decimal digit of the cascade: counts 0..9 on enable and flags a
// carry in the same cycle it rolls from 9 back to 0.
module bcd_digit
   import bcd_count3_timer_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   output logic [DIGIT_W-1:0] value,
   output logic               carry
);

   logic [DIGIT_W-1:0] r_value;

   // Step the digit on enable; anything at or above 9 (including unreachable codes) returns to 0
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_value <= '0;
      end else if (clear) begin
         r_value <= '0;
      end else if (enable) begin
         if (r_value >= DIGIT_MAX) begin
            r_value <= '0;
         end else begin
            r_value <= r_value + 4'd1;
         end
      end
   end

   assign carry = enable & isDigitMax(r_value);
   assign value = r_value;

endmodule

// File: rtl/bcd_count3_timer.sv
// Three-digit BCD stopwatch: a pushbutton toggles run/stop, a prescaler
// divides the clock into count ticks, and three cascaded digits count 000..999.
module bcd_count3_timer
   import bcd_count3_timer_pkg::*;
#(
   parameter int DIV = DEFAULT_DIV
)(
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start_Stop,
   input  logic               Clear,
   output logic [DIGIT_W-1:0] BCD0,
   output logic [DIGIT_W-1:0] BCD1,
   output logic [DIGIT_W-1:0] BCD2,
   output logic               Running,
   output logic               Wrap
);

   localparam int PRESC_W = $clog2(DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_syncPrev;
   logic               r_primed;
   logic               r_armed;
   logic               w_toggle;
   timerState_t        r_state;
   timerState_t        w_stateNext;
   logic               r_running;
   logic [PRESC_W-1:0] r_presc;
   logic               w_tick;
   logic               w_carry0;
   logic               w_carry1;
   logic               w_carry2;
   logic               r_wrap;

   // Bring the pushbutton into the clock domain and keep the previous synchronized level for edge detection
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_syncPrev <= 1'b0;
      end else begin
         r_sync1    <= Start_Stop;
         r_sync2    <= r_sync1;
         r_syncPrev <= r_sync2;
      end
   end

   // Only arm the detector once the button has really been seen low, so a button held through reset is not a press
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_primed <= 1'b0;
         r_armed  <= 1'b0;
      end else begin
         r_primed <= 1'b1;
         r_armed  <= r_armed | (r_primed & ~r_sync1);
      end
   end

   assign w_toggle = r_armed & r_sync2 & ~r_syncPrev;

   // Run/stop state register, with Running kept as its own flop so the output has no decode logic
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state   <= STOP;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_running <= (w_stateNext == RUN);
      end
   end

   // Each detected press flips between STOP and RUN; Clear leaves the state alone
   always_comb begin
      w_stateNext = r_state;
      if (w_toggle) begin
         case (r_state)
            STOP: w_stateNext = RUN;
            RUN:  w_stateNext = STOP;
         endcase
      end
   end

   assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST);

   // Prescaler counts only while running and holds its partial period across a stop
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_presc <= '0;
      end else if (Clear) begin
         r_presc <= '0;
      end else if (r_state == RUN) begin
         if (w_tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PRESC_ONE;
         end
      end
   end

   bcd_digit u_digit0 (
      .clock  (Clock),
      .reset  (Reset),
      .clear  (Clear),
      .enable (w_tick),
      .value  (BCD0),
      .carry  (w_carry0)
   );

   bcd_digit u_digit1 (
      .clock  (Clock),
      .reset  (Reset),
      .clear  (Clear),
      .enable (w_carry0),
      .value  (BCD1),
      .carry  (w_carry1)
   );

   bcd_digit u_digit2 (
      .clock  (Clock),
      .reset  (Reset),
      .clear  (Clear),
      .enable (w_carry1),
      .value  (BCD2),
      .carry  (w_carry2)
   );

   // Flag the 999->000 rollover in the cycle the digits show 000; a simultaneous Clear suppresses it
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_carry2 & ~Clear;
      end
   end

   assign Running = r_running;
   assign Wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_count3_timer.sv
// Directed bench for the BCD timer with a 4-cycle tick: a per-cycle vector
// table for start-up, counting and clear, then hand-written corner sequences.
module tb_bcd_count3_timer;

   localparam int DIV = 4;

   typedef struct {
      logic        startStop;
      logic        clear;
      logic [11:0] expDigits;
      logic        expRunning;
      logic        expWrap;
   } vec_t;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   badSteps = 0;
   vec_t vecs[$];

   bcd_count3_timer_if dutIf();

   bcd_count3_timer #(.DIV(DIV)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Start_Stop (dutIf.startStop),
      .Clear      (dutIf.clear),
      .BCD0       (dutIf.bcd0),
      .BCD1       (dutIf.bcd1),
      .BCD2       (dutIf.bcd2),
      .Running    (dutIf.running),
      .Wrap       (dutIf.wrap)
   );

   // Free-running clock, 10 time units per period
   always #5 Clock = ~Clock;

   function automatic logic [11:0] bcdInc(input logic [11:0] d);
      int n;
      n = int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
      n = (n + 1) % 1000;
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic vec_t mkVec(input logic ss, input logic clr, input logic [11:0] dig, input logic run);
      vec_t v;
      v.startStop  = ss;
      v.clear      = clr;
      v.expDigits  = dig;
      v.expRunning = run;
      v.expWrap    = 1'b0;
      return v;
   endfunction

   task automatic applyStimulus(input logic ss, input logic clr);
      dutIf.startStop = ss;
      dutIf.clear     = clr;
      @(posedge Clock);
      #1;
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [11:0] expDigits,
                              input logic expRunning, input logic expWrap);
      logic [11:0] gotDigits;
      gotDigits = {dutIf.bcd2, dutIf.bcd1, dutIf.bcd0};
      checks++;
      if (gotDigits !== expDigits || dutIf.running !== expRunning || dutIf.wrap !== expWrap) begin
         failures++;
         $display("[TB] FAIL %s: got digits=%03h running=%b wrap=%b, expected digits=%03h running=%b wrap=%b",
                  name, gotDigits, dutIf.running, dutIf.wrap, expDigits, expRunning, expWrap);
      end
   endtask

   task automatic checkFlag(input string name, input int got, input int expected);
      checks++;
      if (got != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expected);
      end
   endtask

   task automatic doReset(input logic holdStart);
      Reset           = 1'b1;
      dutIf.startStop = holdStart;
      dutIf.clear     = 1'b0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      @(posedge Clock);
      #1;
   endtask

   task automatic runUntil(input logic [11:0] target, input int maxCycles, output bit found);
      logic [11:0] prev;
      logic [11:0] cur;
      found = 1'b0;
      prev  = {dutIf.bcd2, dutIf.bcd1, dutIf.bcd0};
      for (int i = 0; i < maxCycles && !found; i++) begin
         @(posedge Clock);
         #1;
         cur = {dutIf.bcd2, dutIf.bcd1, dutIf.bcd0};
         if (dutIf.wrap !== 1'b0) badSteps++;
         if (cur !== prev) begin
            if (cur !== bcdInc(prev)) badSteps++;
            prev = cur;
         end
         if (cur === target) found = 1'b1;
      end
   endtask

   // Abort a run that has stopped making progress
   initial begin
      #1000000;
      failures++;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Main test sequence
   initial begin
      bit found;

      dutIf.startStop = 1'b0;
      dutIf.clear     = 1'b0;

      vecs.push_back(mkVec(1'b1, 1'b0, 12'h000, 1'b0));
      vecs.push_back(mkVec(1'b0, 1'b0, 12'h000, 1'b0));
      vecs.push_back(mkVec(1'b0, 1'b0, 12'h000, 1'b1));
      repeat (3) vecs.push_back(mkVec(1'b0, 1'b0, 12'h000, 1'b1));
      vecs.push_back(mkVec(1'b0, 1'b0, 12'h001, 1'b1));
      repeat (3) vecs.push_back(mkVec(1'b0, 1'b0, 12'h001, 1'b1));
      vecs.push_back(mkVec(1'b0, 1'b0, 12'h002, 1'b1));
      repeat (3) vecs.push_back(mkVec(1'b0, 1'b0, 12'h002, 1'b1));
      vecs.push_back(mkVec(1'b0, 1'b0, 12'h003, 1'b1));
      vecs.push_back(mkVec(1'b0, 1'b1, 12'h000, 1'b1));
      repeat (3) vecs.push_back(mkVec(1'b0, 1'b0, 12'h000, 1'b1));
      vecs.push_back(mkVec(1'b0, 1'b0, 12'h001, 1'b1));

      $display("[TB] start-up, counting and clear vectors");
      doReset(1'b0);
      checkOutput("resetState", 12'h000, 1'b0, 1'b0);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].startStop, vecs[i].clear);
         checkOutput($sformatf("vec%0d", i), vecs[i].expDigits, vecs[i].expRunning, vecs[i].expWrap);
      end

      $display("[TB] rollover 998 -> 999 -> 000");
      doReset(1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      runUntil(12'h998, 5000, found);
      checkFlag("b_reach998", int'(found), 1);
      stepCycles(3);
      checkOutput("b_hold998", 12'h998, 1'b1, 1'b0);
      stepCycles(1);
      checkOutput("b_reach999", 12'h999, 1'b1, 1'b0);
      stepCycles(3);
      checkOutput("b_hold999", 12'h999, 1'b1, 1'b0);
      stepCycles(1);
      checkOutput("b_wrap", 12'h000, 1'b1, 1'b1);
      stepCycles(1);
      checkOutput("b_wrapOnce", 12'h000, 1'b1, 1'b0);
      checkFlag("b_stepErrors", badSteps, 0);

      $display("[TB] clear coinciding with tick at 009");
      doReset(1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      runUntil(12'h009, 100, found);
      checkFlag("c_reach009", int'(found), 1);
      stepCycles(3);
      checkOutput("c_beforeTick", 12'h009, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("c_clearAtTick", 12'h000, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      stepCycles(2);
      checkOutput("c_freshPeriod", 12'h000, 1'b1, 1'b0);
      stepCycles(1);
      checkOutput("c_tickAfterClear", 12'h001, 1'b1, 1'b0);

      $display("[TB] stop mid-period and resume");
      doReset(1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      stepCycles(5);
      checkOutput("d_firstTick", 12'h001, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      stepCycles(1);
      checkOutput("d_stopped", 12'h001, 1'b0, 1'b0);
      stepCycles(10);
      checkOutput("d_holdStop", 12'h001, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      stepCycles(1);
      checkOutput("d_restart", 12'h001, 1'b1, 1'b0);
      stepCycles(1);
      checkOutput("d_resumeTick", 12'h002, 1'b1, 1'b0);
      stepCycles(3);
      checkOutput("d_fullPeriod", 12'h002, 1'b1, 1'b0);
      stepCycles(1);
      checkOutput("d_nextTick", 12'h003, 1'b1, 1'b0);

      $display("[TB] asynchronous reset at 057");
      doReset(1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      runUntil(12'h057, 400, found);
      checkFlag("e_reach057", int'(found), 1);
      stepCycles(1);
      #3 Reset = 1'b1;
      #1 checkOutput("e_asyncReset", 12'h000, 1'b0, 1'b0);
      #2 Reset = 1'b0;
      @(posedge Clock);
      #1;
      stepCycles(10);
      checkOutput("e_noResume", 12'h000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      stepCycles(1);
      checkOutput("e_restart", 12'h000, 1'b1, 1'b0);
      stepCycles(3);
      checkOutput("e_freshPeriod", 12'h000, 1'b1, 1'b0);
      stepCycles(1);
      checkOutput("e_firstTick", 12'h001, 1'b1, 1'b0);

      $display("[TB] button held high through reset release");
      doReset(1'b1);
      stepCycles(8);
      checkOutput("f_heldHighNoToggle", 12'h000, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      stepCycles(3);
      checkOutput("f_releasedLow", 12'h000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("f_beforeLatency", 12'h000, 1'b0, 1'b0);
      stepCycles(1);
      checkOutput("f_startAfterLow", 12'h000, 1'b1, 1'b0);
      dutIf.startStop = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_count3_timer.md
BCD_COUNT3_TIMER -- requirements
Module: bcd_count3_timer

Interface
REQ-001 SHALL have parameter DIV, default 50000000, meaning Clock cycles per count tick (legal range 2 to 2^26).
REQ-002 SHALL have port Clock, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1, meaning asynchronous active-high reset.
REQ-004 SHALL have port Start_Stop, input, 1, meaning asynchronous level from pushbutton; each rising edge toggles run/stop.
REQ-005 SHALL have port Clear, input, 1, meaning synchronous active-high clear of digits and prescaler.
REQ-006 SHALL have port BCD0, output, 4, meaning registered ones digit, feeding a 7-segment decoder.
REQ-007 SHALL have port BCD1, output, 4, meaning registered tens digit.
REQ-008 SHALL have port BCD2, output, 4, meaning registered hundreds digit.
REQ-009 SHALL have port Running, output, 1, meaning 1 while in state RUN.
REQ-010 SHALL have port Wrap, output, 1, meaning one-cycle pulse on the 999->000 transition.

Function
REQ-011 SHALL pass Start_Stop through a two-flop synchronizer, then a registered edge detector; the toggle takes effect 3 cycles after the input rises.
REQ-012 SHALL implement a two-state FSM: STOP and RUN; a detected rising edge moves STOP->RUN or RUN->STOP; no other transitions.
REQ-013 SHALL hold the prescaler (width ceil(log2(DIV))) while in STOP; in RUN it counts 0..DIV-1 and wraps to 0.
REQ-014 SHALL assert internal tick for exactly one cycle when the prescaler equals DIV-1 in RUN; tick period is DIV cycles.
REQ-015 SHALL increment BCD0 on tick; 9->0 generates a carry that increments BCD1 in the same cycle; BCD1 9->0 with carry increments BCD2.
REQ-016 SHALL, on tick with value 999, load 000 and assert Wrap in the same cycle the digits become 000.
REQ-017 SHALL keep each digit in 0..9 at all times; a digit value above 9 is unreachable and SHALL be forced to 0 on its next enable.
REQ-018 SHALL, when Clear=1, load digits to 000 and prescaler to 0 on the next edge, regardless of state; FSM state is unchanged.
REQ-019 SHALL give Clear priority over tick in the same cycle: digits become 000, Wrap stays 0.
REQ-020 SHALL, when a toggle edge and a tick coincide, apply the tick; the state change takes effect on the same edge, and no further ticks occur after RUN->STOP.
REQ-021 SHALL resume from the held prescaler value after STOP->RUN (no restart of the partial period).
REQ-022 SHALL drive all outputs directly from flops; no combinational path from any input to any output.

Reset
REQ-023 SHALL, on Reset=1, immediately set state STOP, prescaler 0, BCD2/BCD1/BCD0 = 0, Wrap 0, Running 0, synchronizer and edge flops 0.
REQ-024 SHALL abandon any in-progress period on Reset mid-count; after release the block resumes counting only after a new Start_Stop rising edge.
REQ-025 SHALL not detect a toggle when Start_Stop is already high at reset release; only a subsequent 0->1 transition counts.

Structure
REQ-026 SHALL place the digit maximum (9), the FSM state encodings (STOP, RUN) and the default DIV in a shared package/include for reuse by display blocks.
REQ-027 SHALL use one sub-module bcd_digit (ports: clock, reset, clear, enable in, 4-bit value, carry out), instantiated three times in a cascade.

Verification (DIV=4)
REQ-028 SHALL verify that Reset followed by a Start_Stop pulse makes Running rise 3 cycles after the input edge, with BCD0 at 1, 2, 3 at 4-cycle intervals.
REQ-029 SHALL verify that preloading digits to 998 and running for 8 cycles reaches 999 then 000, with Wrap high for exactly 1 cycle when 000 appears.
REQ-030 SHALL verify that Clear asserted in the tick cycle at value 009 gives 000, Wrap 0, and Running unchanged.
REQ-031 SHALL verify that a stop pulse at prescaler=2, held 10 cycles, then a start pulse gives the next BCD0 increment 1 cycle (plus toggle latency) after restart, with no increment during STOP.
REQ-032 SHALL verify that asserting Reset asynchronously mid-period at value 057 clears outputs to 000 and Running 0 before the next Clock edge.
REQ-033 SHALL verify that holding Start_Stop high through reset release produces no toggle, and that only a 0->1 transition starts counting.
